instr_encoder: RTL and testbench

- Sequential MIPS instruction encoder, the inverse of the control/ALU-control decoder.
- Accepts symbolic instruction requests (operation class plus register/immediate/target fields) on a valid/ready handshake.
- Emits 32-bit machine words on a second valid/ready stream, expanding pseudo-instructions (NOP, MOVE, LI, BLT, BGE) into 1–3 real words.
- Used by the self-test program loader and instruction-memory initialisation path; every word it emits uses only opcodes/functs the decoder supports.

---
 rtl/instr_encoder_pkg.sv | 63 ++++++
 rtl/instr_encoder_word_builder.sv | 70 +++++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder: request op codes, machine
// opcode/funct fields (common with the decoder), FSM states and request record.
package instr_encoder_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_LW   = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_BEQ  = 5'd8;
    localparam logic [4:0] OP_BNE  = 5'd9;
    localparam logic [4:0] OP_J    = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ORI  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_MOVE = 5'd14;
    localparam logic [4:0] OP_LI   = 5'd15;
    localparam logic [4:0] OP_BLT  = 5'd16;
    localparam logic [4:0] OP_BGE  = 5'd17;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {ST_IDLE, ST_W0, ST_W1, ST_W2} state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [25:0] target;
    } req_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_word_builder.sv
// Combinational map from a request record and word index to one machine word,
// its last-word flag and the unsupported-op flag.
module instr_word_builder
    import instr_encoder_pkg::*;
#(
    parameter int AT_REG = 1
) (
    input  req_t        req,
    input  logic [1:0]  idx,
    output logic [31:0] instr,
    output logic        last,
    output logic        err
);

    localparam logic [4:0] AT = AT_REG[4:0];

    logic li_short;

    always_comb begin
        instr    = 32'h0000_0000;
        last     = 1'b1;
        err      = 1'b0;
        // Sign-extended 16-bit immediate reproduces the full value: one ADDI suffices.
        li_short = (&req.imm[31:15]) || !(|req.imm[31:15]);
        case (req.op)
            OP_ADD:  instr = r_word(req.rs, req.rt, req.rd, 5'd0, FN_ADD);
            OP_SUB:  instr = r_word(req.rs, req.rt, req.rd, 5'd0, FN_SUB);
            OP_AND:  instr = r_word(req.rs, req.rt, req.rd, 5'd0, FN_AND);
            OP_OR:   instr = r_word(req.rs, req.rt, req.rd, 5'd0, FN_OR);
            OP_SLT:  instr = r_word(req.rs, req.rt, req.rd, 5'd0, FN_SLT);
            OP_SLL:  instr = r_word(5'd0, req.rt, req.rd, req.shamt, FN_SLL);
            OP_LW:   instr = i_word(OPC_LW, req.rs, req.rt, req.imm[15:0]);
            OP_SW:   instr = i_word(OPC_SW, req.rs, req.rt, req.imm[15:0]);
            OP_BEQ:  instr = i_word(OPC_BEQ, req.rs, req.rt, req.imm[15:0]);
            OP_BNE:  instr = i_word(OPC_BNE, req.rs, req.rt, req.imm[15:0]);
            OP_J:    instr = {OPC_J, req.target};
            OP_ADDI: instr = i_word(OPC_ADDI, req.rs, req.rt, req.imm[15:0]);
            OP_ORI:  instr = i_word(OPC_ORI, req.rs, req.rt, req.imm[15:0]);
            OP_NOP:  instr = 32'h0000_0000;
            OP_MOVE: instr = r_word(req.rs, 5'd0, req.rd, 5'd0, FN_ADD);
            OP_LI: begin
                if (li_short) begin
                    instr = i_word(OPC_ADDI, 5'd0, req.rt, req.imm[15:0]);
                end else begin
                    case (idx)
                        2'd0: begin
                            instr = i_word(OPC_ORI, 5'd0, req.rt, req.imm[31:16]);
                            last  = 1'b0;
                        end
                        2'd1: begin
                            instr = r_word(5'd0, req.rt, req.rt, 5'd16, FN_SLL);
                            last  = (req.imm[15:0] == 16'h0000);
                        end
                        default: instr = i_word(OPC_ORI, req.rt, req.rt, req.imm[15:0]);
                    endcase
                end
            end
            OP_BLT, OP_BGE: begin
                if (idx == 2'd0) begin
                    instr = r_word(req.rs, req.rt, AT, 5'd0, FN_SLT);
                    last  = 1'b0;
                end else begin
                    instr = i_word((req.op == OP_BLT) ? OPC_BNE : OPC_BEQ, AT, 5'd0, req.imm[15:0]);
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: accepts symbolic requests and streams 1-3 machine
// words per request through a registered valid/ready output.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int AT_REG = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] word_cnt
);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    req_t             in_req, build_req;
    logic [1:0]       build_idx;
    logic [31:0]      instr_q, instr_d, build_instr;
    logic             last_q, last_d, build_last;
    logic             err_q, err_d, build_err;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             accept, fire;

    assign in_req    = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                         imm: in_imm, target: in_target};
    assign out_valid = (state_q != ST_IDLE);
    assign fire      = out_valid && out_ready;
    assign in_ready  = !out_valid || (out_ready && last_q);
    assign accept    = in_valid && in_ready;

    // A newly accepted request builds its first word straight from the input
    // fields; later words come from the latched copy.
    assign build_req = accept ? in_req : req_q;
    assign build_idx = accept ? 2'd0 : ((state_q == ST_W0) ? 2'd1 : 2'd2);

    instr_word_builder #(.AT_REG(AT_REG)) u_builder (
        .req   (build_req),
        .idx   (build_idx),
        .instr (build_instr),
        .last  (build_last),
        .err   (build_err)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        instr_d    = instr_q;
        last_d     = last_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q + CNT_W'(fire);
        if (accept) begin
            req_d   = in_req;
            instr_d = build_instr;
            last_d  = build_last;
            err_d   = build_err;
            state_d = ST_W0;
        end else if (fire) begin
            if (last_q) begin
                state_d = ST_IDLE;
            end else begin
                instr_d = build_instr;
                last_d  = build_last;
                err_d   = build_err;
                state_d = (state_q == ST_W0) ? ST_W1 : ST_W2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            instr_q    <= 32'h0000_0000;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            last_q     <= last_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign out_instr = instr_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues hand-computed words,
// a negedge monitor pops and compares each word the consumer accepts.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [31:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;
    logic [15:0] word_cnt;

    int          nvec = 0;
    int          errs = 0;
    int          cycle = 0;
    logic [33:0] sb[$];

    instr_encoder #(.AT_REG(1), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .out_err   (out_err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request; returns at posedge+1 right after it was accepted.
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [31:0] imm,
                        input logic [25:0] tgt, input int n, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] w2, input logic err);
        logic acc;
        int   k;
        for (int i = 0; i < n; i++)
            sb.push_back({err, (i == n - 1), (i == 0) ? w0 : ((i == 1) ? w1 : w2)});
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
        in_imm = imm; in_target = tgt; in_valid = 1'b1;
        acc = 1'b0;
        for (k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        $display("req op=%0d imm=%h words=%0d accepted at cycle %0d", op, imm, n, cycle);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word handed to the consumer must match the queue head.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    errs++;
                    $display("FAIL unexpected_word got %h err=%b last=%b expected none",
                             out_instr, out_err, out_last);
                end else begin
                    e = sb.pop_front();
                    chk("word", {30'd0, out_err, out_last, out_instr}, {30'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        #14 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0, 1, 32'h00221820, 0, 0, 1'b0);
        chk("add_latency_valid", 64'(out_valid), 64'd1);
        chk("add_latency_last", 64'(out_last), 64'd1);
        @(posedge clk);
        #1;
        chk("add_word_cnt", 64'(word_cnt), 64'd1);

        send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0, 3,
             32'h34081234, 32'h00084400, 32'h35085678, 1'b0);
        chk("li3_ready_w0", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("li3_ready_w1", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("li3_ready_w2", 64'(in_ready), 64'd1);

        send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFFFFFE, 26'd0, 1, 32'h2008FFFE, 0, 0, 1'b0);
        send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 32'h00120000, 26'd0, 2,
             32'h34080012, 32'h00084400, 0, 1'b0);
        drain();
        chk("cnt_before_blt", 64'(word_cnt), 64'd7);

        out_ready = 1'b0;
        send(5'd16, 5'd4, 5'd5, 5'd0, 5'd0, 32'h00000003, 26'd0, 2,
             32'h0085082A, 32'h14200003, 0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_instr", 64'(out_instr), 64'h14200003);
            chk("stall_last", 64'(out_last), 64'd1);
            chk("stall_word_cnt", 64'(word_cnt), 64'd8);
        end
        out_ready = 1'b1;

        send(5'd17, 5'd2, 5'd3, 5'd0, 5'd0, 32'h0000FFFE, 26'd0, 2,
             32'h0043082A, 32'h1020FFFE, 0, 1'b0);
        send(5'd5, 5'd0, 5'd10, 5'd9, 5'd4, 32'd0, 26'd0, 1, 32'h000A4900, 0, 0, 1'b0);
        send(5'd6, 5'd29, 5'd8, 5'd0, 5'd0, 32'h00000010, 26'd0, 1, 32'h8FA80010, 0, 0, 1'b0);
        send(5'd14, 5'd5, 5'd0, 5'd4, 5'd0, 32'd0, 26'd0, 1, 32'h00A02020, 0, 0, 1'b0);
        send(5'd13, 5'd7, 5'd7, 5'd7, 5'd0, 32'd0, 26'd0, 1, 32'h00000000, 0, 0, 1'b0);
        send(5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h0100000, 1, 32'h08100000, 0, 0, 1'b0);
        send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h1234, 26'd0, 1, 32'h00000000, 0, 0, 1'b1);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0, 1, 32'h00221820, 0, 0, 1'b0);
        drain();

        t0 = cycle;
        for (int i = 0; i < 10; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 10);
            send(5'd0, 5'd1, 5'd2, rd, 5'd0, 32'd0, 26'd0, 1,
                 32'h00220020 | (32'(rd) << 11), 0, 0, 1'b0);
        end
        chk("b2b_cycles", 64'(cycle - t0), 64'd10);
        drain();

        out_ready = 1'b0;
        send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0, 3,
             32'h34081234, 32'h00084400, 32'h35085678, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_instr", 64'(out_instr), 64'd0);
        chk("midrst_out_last", 64'(out_last), 64'd0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("midrst_dropped", 64'(sb.size()), 64'd2);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
